mem_bus_decoder: RTL
====================

Name: mem_bus_decoder

Overview:
- Parametrised, registered address decoder and bus router between the CPU memory port (valid/ready, single outstanding access) and up to NUM_SLAVES memory-mapped devices.
- Matches each address against per-slave base/mask regions and drives a one-hot enable plus a request to the selected slave.
- Muxes read data back to the CPU and returns an error response for unmapped addresses or slaves that do not answer within TIMEOUT cycles.

Parameters:
- NUM_SLAVES, 8, number of slave ports (1..16)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; WSTRB width is DATA_WIDTH/8
- REGION_BASE, {NUM_SLAVES*ADDR_WIDTH}, packed bases, slave i at [i*ADDR_WIDTH +: ADDR_WIDTH]; default slave0=0x00000000, slave1=0x20000000, others 0xFFFFFFFF
- REGION_MASK, {NUM_SLAVES*ADDR_WIDTH}, packed masks; default slave0=0xFFFF0000, slave1=0xFFFFFFF0, others 0 (mask 0 with non-zero base = region disabled)
- TIMEOUT, 255, max ACCESS cycles before error; 0 disables timeout
- ERROR_RDATA, 32'hDEADBEEF, read data returned on error

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- mem_valid  in  1  CPU request; held high until mem_ready
- mem_addr  in  ADDR_WIDTH  CPU address
- mem_wdata  in  DATA_WIDTH  CPU write data
- mem_wstrb  in  DATA_WIDTH/8  byte strobes; 0 = read
- mem_ready  out  1  one-cycle completion pulse
- mem_rdata  out  DATA_WIDTH  read data, valid with mem_ready
- mem_error  out  1  error flag, valid with mem_ready
- enables  out  NUM_SLAVES  one-hot slave select, registered
- slv_valid  out  1  request to selected slave
- slv_addr  out  ADDR_WIDTH  latched address
- slv_wdata  out  DATA_WIDTH  latched write data
- slv_wstrb  out  DATA_WIDTH/8  latched strobes
- slv_rdata  in  NUM_SLAVES*DATA_WIDTH  packed slave read data
- slv_ready  in  NUM_SLAVES  per-slave completion

Behaviour:
- Reset (async, resetn=0): state IDLE; every output 0; timeout counter 0. Reset mid-transaction aborts it silently, with no mem_ready.
- Match: hit[i] = ((mem_addr & MASK[i]) == BASE[i]). With multiple hits, the lowest index wins.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - On mem_valid with a hit: latch addr/wdata/wstrb to slv_*, set enables = onehot(sel), slv_valid = 1, counter = 0, go to ACCESS.
  - On mem_valid with no hit: mem_rdata = ERROR_RDATA, mem_error = 1, mem_ready = 1, go to RESP.
- ACCESS:
  - slv_valid and enables held stable. Counter increments each cycle.
  - slv_ready[sel] = 1: register slv_rdata slice sel into mem_rdata, mem_error = 0, mem_ready = 1, clear slv_valid/enables, go to RESP.
  - Else, if TIMEOUT != 0 and counter == TIMEOUT-1: mem_rdata = ERROR_RDATA, mem_error = 1, mem_ready = 1, clear slv_valid/enables, go to RESP.
  - If slv_ready[sel] and the timeout fire in the same cycle, the slave response wins.
  - slv_ready from non-selected slaves is ignored in every state.
- RESP: mem_ready = 1 for this single cycle only. Next cycle clear mem_ready/mem_error and go to IDLE. mem_valid is not sampled in RESP.
- mem_rdata holds its value until the next response. On writes, mem_rdata carries the slave's rdata unchanged.
- Latency, mapped: mem_valid sampled at edge 0 → slv_valid at cycle 1 → earliest mem_ready at cycle 2.
- Latency, unmapped: mem_ready at cycle 1.
- Throughput: one transaction per 3 cycles minimum.
- mem_valid dropped mid-transaction is illegal. The block still completes the transaction and pulses mem_ready.
- Counter width: $clog2(TIMEOUT+1), saturating, no wrap.

Decomposition:
- Shared package mem_bus_pkg holds:
  - state encoding localparams (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2)
  - default ERROR_RDATA
  - default region base/mask constants for the SoC memory map
- One combinational sub-module, mem_region_match: takes address, REGION_BASE and REGION_MASK; outputs hit (1 bit) and sel (index, lowest-priority encode). Used once in IDLE decode.

Test Plan:
- Read slave0 at 0x00000010, slave0 ready 1 cycle after slv_valid with rdata 0x12345678 → enables=0x01, slv_addr=0x00000010, mem_ready pulse at cycle 3, mem_rdata=0x12345678, mem_error=0.
- Write 0xCAFEF00D wstrb=0xF to 0x20000004 (slave1), ready immediate → enables=0x02, slv_wdata=0xCAFEF00D, slv_wstrb=0xF, mem_ready at cycle 2, mem_error=0.
- Read unmapped 0x40000000 → no enables, slv_valid stays 0, mem_ready at cycle 1 with mem_error=1, mem_rdata=0xDEADBEEF.
- Slave1 never ready, TIMEOUT=4 → slv_valid high exactly 4 cycles, then mem_ready with mem_error=1, mem_rdata=0xDEADBEEF, enables=0.
- Overlap: slave2 configured base=0x0, mask=0xFFFF0000; access 0x00000100 → enables=0x01 (slave0 priority). Spurious slv_ready[2] during slave0 ACCESS is ignored.
- Assert resetn=0 in ACCESS → all outputs 0 immediately, no mem_ready. After release, a new read to slave0 completes normally.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the CPU memory-port decoder: FSM encoding,
// error read data and the default SoC memory map (32-bit addresses, up to 16 slaves).
package mem_bus_pkg;

    localparam int MAX_SLAVES = 16;

    localparam logic [1:0] STATE_IDLE   = 2'd0;
    localparam logic [1:0] STATE_ACCESS = 2'd1;
    localparam logic [1:0] STATE_RESP   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = STATE_IDLE,
        ST_ACCESS = STATE_ACCESS,
        ST_RESP   = STATE_RESP
    } state_t;

    localparam logic [31:0] DEFAULT_ERROR_RDATA = 32'hDEADBEEF;

    // Slave0 = 64 KiB at 0, slave1 = 16 B at 0x2000_0000, the rest disabled
    // (zero mask with a non-zero base can never match).
    localparam logic [MAX_SLAVES*32-1:0] DEFAULT_REGION_BASE =
        {{(MAX_SLAVES-2){32'hFFFF_FFFF}}, 32'h2000_0000, 32'h0000_0000};
    localparam logic [MAX_SLAVES*32-1:0] DEFAULT_REGION_MASK =
        {{(MAX_SLAVES-2){32'h0000_0000}}, 32'hFFFF_FFF0, 32'hFFFF_0000};

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_region_match.sv
// Combinational base/mask region match; on overlapping regions the
// lowest slave index wins.
module mem_region_match
    import mem_bus_pkg::*;
#(
    parameter int NUM_SLAVES = 8,
    parameter int ADDR_WIDTH = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] REGION_BASE = DEFAULT_REGION_BASE[NUM_SLAVES*ADDR_WIDTH-1:0],
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] REGION_MASK = DEFAULT_REGION_MASK[NUM_SLAVES*ADDR_WIDTH-1:0]
) (
    input  logic [ADDR_WIDTH-1:0]                addr,
    output logic                                 hit,
    output logic [sel_width(NUM_SLAVES)-1:0]     sel
);

    localparam int SEL_W = sel_width(NUM_SLAVES);

    logic [NUM_SLAVES-1:0] hit_vec;

    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_match
            assign hit_vec[gi] = ((addr & REGION_MASK[gi*ADDR_WIDTH +: ADDR_WIDTH])
                                  == REGION_BASE[gi*ADDR_WIDTH +: ADDR_WIDTH]);
        end
    endgenerate

    assign hit = |hit_vec;

    // Scan downwards so the last assignment is the lowest matching index.
    always_comb begin
        sel = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                sel = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_bus_decoder.sv
// Registered address decoder / router between a single-outstanding CPU
// memory port and up to NUM_SLAVES memory-mapped devices, with timeout.
module mem_bus_decoder
    import mem_bus_pkg::*;
#(
    parameter int NUM_SLAVES = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] REGION_BASE = DEFAULT_REGION_BASE[NUM_SLAVES*ADDR_WIDTH-1:0],
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] REGION_MASK = DEFAULT_REGION_MASK[NUM_SLAVES*ADDR_WIDTH-1:0],
    parameter int TIMEOUT = 255,
    parameter logic [DATA_WIDTH-1:0] ERROR_RDATA = DATA_WIDTH'(DEFAULT_ERROR_RDATA)
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             mem_valid,
    input  logic [ADDR_WIDTH-1:0]            mem_addr,
    input  logic [DATA_WIDTH-1:0]            mem_wdata,
    input  logic [DATA_WIDTH/8-1:0]          mem_wstrb,
    output logic                             mem_ready,
    output logic [DATA_WIDTH-1:0]            mem_rdata,
    output logic                             mem_error,
    output logic [NUM_SLAVES-1:0]            enables,
    output logic                             slv_valid,
    output logic [ADDR_WIDTH-1:0]            slv_addr,
    output logic [DATA_WIDTH-1:0]            slv_wdata,
    output logic [DATA_WIDTH/8-1:0]          slv_wstrb,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slv_rdata,
    input  logic [NUM_SLAVES-1:0]            slv_ready
);

    localparam int SEL_W = sel_width(NUM_SLAVES);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic                    mem_ready_reg, mem_ready_next;
    logic                    mem_error_reg, mem_error_next;
    logic [DATA_WIDTH-1:0]   mem_rdata_reg, mem_rdata_next;
    logic [NUM_SLAVES-1:0]   enables_reg, enables_next;
    logic                    slv_valid_reg, slv_valid_next;
    logic [ADDR_WIDTH-1:0]   slv_addr_reg, slv_addr_next;
    logic [DATA_WIDTH-1:0]   slv_wdata_reg, slv_wdata_next;
    logic [DATA_WIDTH/8-1:0] slv_wstrb_reg, slv_wstrb_next;

    logic                    match_hit;
    logic [SEL_W-1:0]        match_sel;
    logic                    slave_done;
    logic [DATA_WIDTH-1:0]   rdata_masked [NUM_SLAVES];
    logic [DATA_WIDTH-1:0]   sel_rdata;

    mem_region_match #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .REGION_BASE(REGION_BASE),
        .REGION_MASK(REGION_MASK)
    ) u_match (
        .addr(mem_addr),
        .hit (match_hit),
        .sel (match_sel)
    );

    // The one-hot enable doubles as the return-path select, so ready and
    // data from non-selected slaves are masked out here.
    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_rmux
            assign rdata_masked[gi] = slv_rdata[gi*DATA_WIDTH +: DATA_WIDTH]
                                      & {DATA_WIDTH{enables_reg[gi]}};
        end
    endgenerate

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel_rdata = sel_rdata | rdata_masked[i];
        end
    end

    assign slave_done = |(slv_ready & enables_reg);

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        mem_ready_next = 1'b0;
        mem_error_next = mem_error_reg;
        mem_rdata_next = mem_rdata_reg;
        enables_next   = enables_reg;
        slv_valid_next = slv_valid_reg;
        slv_addr_next  = slv_addr_reg;
        slv_wdata_next = slv_wdata_reg;
        slv_wstrb_next = slv_wstrb_reg;
        case (state_reg)
            ST_IDLE: begin
                if (mem_valid) begin
                    if (match_hit) begin
                        slv_addr_next  = mem_addr;
                        slv_wdata_next = mem_wdata;
                        slv_wstrb_next = mem_wstrb;
                        enables_next   = NUM_SLAVES'(1) << match_sel;
                        slv_valid_next = 1'b1;
                        cnt_next       = '0;
                        state_next     = ST_ACCESS;
                    end else begin
                        mem_rdata_next = ERROR_RDATA;
                        mem_error_next = 1'b1;
                        mem_ready_next = 1'b1;
                        state_next     = ST_RESP;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_reg != '1) begin
                    cnt_next = cnt_reg + 1'b1;
                end
                // Slave response takes precedence over a same-cycle timeout.
                if (slave_done) begin
                    mem_rdata_next = sel_rdata;
                    mem_error_next = 1'b0;
                    mem_ready_next = 1'b1;
                    enables_next   = '0;
                    slv_valid_next = 1'b0;
                    state_next     = ST_RESP;
                end else if (TIMEOUT != 0 && cnt_reg == CNT_LAST) begin
                    mem_rdata_next = ERROR_RDATA;
                    mem_error_next = 1'b1;
                    mem_ready_next = 1'b1;
                    enables_next   = '0;
                    slv_valid_next = 1'b0;
                    state_next     = ST_RESP;
                end
            end
            ST_RESP: begin
                mem_error_next = 1'b0;
                state_next     = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            mem_ready_reg <= 1'b0;
            mem_error_reg <= 1'b0;
            mem_rdata_reg <= '0;
            enables_reg   <= '0;
            slv_valid_reg <= 1'b0;
            slv_addr_reg  <= '0;
            slv_wdata_reg <= '0;
            slv_wstrb_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            mem_ready_reg <= mem_ready_next;
            mem_error_reg <= mem_error_next;
            mem_rdata_reg <= mem_rdata_next;
            enables_reg   <= enables_next;
            slv_valid_reg <= slv_valid_next;
            slv_addr_reg  <= slv_addr_next;
            slv_wdata_reg <= slv_wdata_next;
            slv_wstrb_reg <= slv_wstrb_next;
        end
    end

    assign mem_ready = mem_ready_reg;
    assign mem_error = mem_error_reg;
    assign mem_rdata = mem_rdata_reg;
    assign enables   = enables_reg;
    assign slv_valid = slv_valid_reg;
    assign slv_addr  = slv_addr_reg;
    assign slv_wdata = slv_wdata_reg;
    assign slv_wstrb = slv_wstrb_reg;

endmodule
